klein80_serial_host: RTL and testbench
======================================

# klein80_serial_host

Host-side driver for the byte-serial KLEIN-80 encryption core (`klein_80`). It accepts a full 64-bit plaintext and an 80-bit key in parallel, then streams them into the core byte by byte with the `start` pulse. It waits for `ready` and collects the eight ciphertext bytes back into a 64-bit word. It sits between the parallel system/DPA-capture controller and the serial core, and it owns the core-side protocol end to end.

## Interface
Parameters:
- `TIMEOUT`, default 1023: maximum number of cycles spent waiting for `core_ready` before the operation aborts. Legal range 16..65535.

Ports:
- `ck`, in, 1: rising-edge clock shared with the core.
- `rst_n`, in, 1: reset, asynchronous and active-low.
- `req`, in, 1: start request. Sampled only in IDLE.
- `pt`, in, 64: plaintext. Byte 0 is `pt[63:56]`; bytes follow MSB-first.
- `key80`, in, 80: key. Byte 0 is `key80[79:72]`.
- `busy`, out, 1: high in every state except IDLE.
- `done`, out, 1: one-cycle pulse marking the end of an operation, whether it succeeded or timed out.
- `err`, out, 1: timeout flag. Set together with `done`; held until the next accepted `req` or reset.
- `ct`, out, 64: ciphertext. Valid from the `done` cycle and held until the next accepted `req`.
- `core_start`, out, 1: core start pulse.
- `core_inp`, out, 8: plaintext byte to the core (core bit 0 = MSB).
- `core_key`, out, 8: key byte to the core.
- `core_ready`, in, 1: ciphertext-available strobe from the core.
- `core_out`, in, 8: ciphertext byte from the core.

## Operation
- All outputs are registered. All state and counters are cleared asynchronously by `rst_n`=0.
- The FSM has five states: IDLE, LOAD, WAIT, UNLOAD, FIN.
- **IDLE**
  - `req`=1 at an edge: latch `pt` and `key80` into shift registers, clear `ct` and `err`, set byte counter to 0, go to LOAD.
  - `req` outside IDLE is ignored (no queueing).
- **LOAD** (10 cycles, counter 0..9)
  - In load cycle k, `core_key` = key byte k.
  - `core_inp` = plaintext byte k for k=0..7, and 0x00 for k=8,9.
  - `core_start`=1 in load cycle 0 only.
  - After cycle 9: reset the watchdog to 0 and go to WAIT.
  - `core_ready` is ignored in LOAD.
- **WAIT**
  - `core_inp` and `core_key` are driven to 0x00.
  - `core_ready`=1 at an edge: capture `core_out` as ct byte 0, set counter to 1, go to UNLOAD.
  - Watchdog reaches `TIMEOUT` with no `core_ready`: set `err`=1 and go to FIN; `ct` stays 0.
- **UNLOAD**
  - Capture `core_out` as ct byte k at each edge, k=1..7, regardless of `core_ready`.
  - After byte 7, go to FIN.
- **FIN**
  - `done`=1 for exactly one cycle, then return to IDLE.
- Bytes are assembled by shift-left-by-8 insertion, so ct byte 0 ends up in `ct[63:56]`.

## Timing
- Reset values: `busy`=0, `done`=0, `err`=0, `ct`=0, `core_start`=0, `core_inp`=0x00, `core_key`=0x00. The state is IDLE.
- Edge E accepts `req`:
  - `busy` and `core_start` rise in the cycle after E (load cycle 0).
  - Key byte 9 is presented in load cycle 9, which is cycle E+10.
- `core_ready` is sampled high at edge R:
  - ct bytes are captured at R, R+1, …, R+7.
  - `done`=1 and the final `ct` appear in the cycle after R+7.
  - `busy` falls one cycle after `done`.
- Back-to-back operation: `req` held high re-launches at the first IDLE edge, i.e. the edge that ends the `done` cycle +1.
- Timeout: `done` and `err` assert `TIMEOUT`+1 cycles after the first WAIT cycle.
- `core_ready` in the same WAIT cycle that the watchdog expires: `core_ready` wins and capture proceeds; `err` stays 0.
- `rst_n` low mid-operation: immediate abort. All outputs take their reset values, the core sees no further bytes, and no `done` is produced.

## Test plan
1. Use a scripted core model that returns bytes 0x11..0x88. `pt`=0x0123456789ABCDEF, `key80`=0xFFEEDDCCBBAA99887766, `req` pulse, `core_ready` 30 cycles after start.
   - `core_start` is high for exactly 1 cycle.
   - `core_inp` sequence is 01 23 45 67 89 AB CD EF 00 00.
   - `core_key` sequence is FF EE … 66.
   - `done` pulses with `ct`=0x1122334455667788 and `err`=0.
2. Hold `req` high continuously with two different vectors.
   - Two complete operations run.
   - The second `core_start` occurs exactly 2 cycles after the first `done`.
   - The first `ct` is held until the second `req` is accepted.
3. `TIMEOUT`=16, core never asserts `core_ready`.
   - `done` and `err` assert 17 cycles into WAIT, with `ct`=0.
   - `err` clears on the next `req`.
4. Pulse `core_ready` during LOAD cycle 5, then again 20 cycles after LOAD.
   - The first pulse is ignored.
   - Capture starts at the second pulse.
5. Pull `rst_n` low in UNLOAD (after 3 bytes captured), then release.
   - All outputs read 0 while in reset.
   - No `done` is produced.
   - A following `req` completes normally.
6. Assert `core_ready` on the exact expiry edge with `TIMEOUT`=16.
   - `err`=0 and `ct` holds the captured bytes.

Source files
------------

// File: rtl/klein80_serial_host.sv
// klein80_serial_host
// Host-side driver for the byte-serial KLEIN-80 core. It takes a parallel
// 64-bit plaintext and 80-bit key and streams them to the core one byte per
// cycle, starting with a core_start pulse. It then waits, under a watchdog,
// for core_ready and assembles the eight returned ciphertext bytes into ct.
//
// Ports
//   ck, rst_n          clock, asynchronous active-low reset
//   req                start request, sampled only while idle
//   pt[63:0]           plaintext, byte 0 = pt[63:56]
//   key80[79:0]        key, byte 0 = key80[79:72]
//   busy               high in every state except idle
//   done               one-cycle end-of-operation pulse (success or timeout)
//   err                timeout flag, held until the next accepted req
//   ct[63:0]           ciphertext, valid from done until the next accepted req
//   core_start         core start pulse (first load cycle)
//   core_inp[7:0]      plaintext byte to the core
//   core_key[7:0]      key byte to the core
//   core_ready         ciphertext-available strobe from the core
//   core_out[7:0]      ciphertext byte from the core
module klein80_serial_host #(
  parameter int unsigned TIMEOUT = 1023
) (
  input  logic        ck,
  input  logic        rst_n,
  input  logic        req,
  input  logic [63:0] pt,
  input  logic [79:0] key80,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic [63:0] ct,
  output logic        core_start,
  output logic [7:0]  core_inp,
  output logic [7:0]  core_key,
  input  logic        core_ready,
  input  logic [7:0]  core_out
);

  localparam logic [15:0] TIMEOUT_C = 16'(TIMEOUT);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_WAIT,
    S_UNLOAD,
    S_FIN
  } state_t;

  state_t      state_q, state_d;
  logic [63:0] pt_sr_q, pt_sr_d;
  logic [79:0] key_sr_q, key_sr_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [15:0] wdog_q, wdog_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        err_q, err_d;
  logic [63:0] ct_q, ct_d;
  logic        start_q, start_d;
  logic [7:0]  inp_q, inp_d;
  logic [7:0]  key_q, key_d;

  always_comb begin
    state_d  = state_q;
    pt_sr_d  = pt_sr_q;
    key_sr_d = key_sr_q;
    cnt_d    = cnt_q;
    wdog_d   = wdog_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    err_d    = err_q;
    ct_d     = ct_q;
    start_d  = 1'b0;
    inp_d    = inp_q;
    key_d    = key_q;

    unique case (state_q)
      S_IDLE: begin
        if (req) begin
          // Byte 0 goes straight out of the accepting edge so that load
          // cycle 0 already presents it; the shift registers keep the rest.
          state_d  = S_LOAD;
          busy_d   = 1'b1;
          start_d  = 1'b1;
          inp_d    = pt[63:56];
          key_d    = key80[79:72];
          pt_sr_d  = {pt[55:0], 8'h00};
          key_sr_d = {key80[71:0], 8'h00};
          ct_d     = '0;
          err_d    = 1'b0;
          cnt_d    = '0;
        end
      end

      S_LOAD: begin
        if (cnt_q == 4'd9) begin
          state_d = S_WAIT;
          wdog_d  = '0;
          inp_d   = '0;
          key_d   = '0;
        end else begin
          // Plaintext shifts in zeros, so load cycles 8 and 9 send 0x00.
          inp_d    = pt_sr_q[63:56];
          key_d    = key_sr_q[79:72];
          pt_sr_d  = {pt_sr_q[55:0], 8'h00};
          key_sr_d = {key_sr_q[71:0], 8'h00};
          cnt_d    = cnt_q + 4'd1;
        end
      end

      S_WAIT: begin
        // core_ready is tested first so it wins on the expiry cycle.
        if (core_ready) begin
          ct_d    = {ct_q[55:0], core_out};
          cnt_d   = 4'd1;
          state_d = S_UNLOAD;
        end else if (wdog_q == TIMEOUT_C) begin
          err_d   = 1'b1;
          done_d  = 1'b1;
          state_d = S_FIN;
        end else begin
          wdog_d = wdog_q + 16'd1;
        end
      end

      S_UNLOAD: begin
        ct_d = {ct_q[55:0], core_out};
        if (cnt_q == 4'd7) begin
          done_d  = 1'b1;
          state_d = S_FIN;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end

      S_FIN: begin
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge ck or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      pt_sr_q  <= '0;
      key_sr_q <= '0;
      cnt_q    <= '0;
      wdog_q   <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
      ct_q     <= '0;
      start_q  <= 1'b0;
      inp_q    <= '0;
      key_q    <= '0;
    end else begin
      state_q  <= state_d;
      pt_sr_q  <= pt_sr_d;
      key_sr_q <= key_sr_d;
      cnt_q    <= cnt_d;
      wdog_q   <= wdog_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      err_q    <= err_d;
      ct_q     <= ct_d;
      start_q  <= start_d;
      inp_q    <= inp_d;
      key_q    <= key_d;
    end
  end

  assign busy       = busy_q;
  assign done       = done_q;
  assign err        = err_q;
  assign ct         = ct_q;
  assign core_start = start_q;
  assign core_inp   = inp_q;
  assign core_key   = key_q;

endmodule

// File: tb/tb_klein80_serial_host.sv
// Testbench for klein80_serial_host: a scripted core model drives one
// default-TIMEOUT instance and one TIMEOUT=16 instance; expected ct/err
// results are queued at stimulus time and compared at each done pulse.
module tb_klein80_serial_host;

  logic        ck = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_v = 1'b0;
  logic [63:0] pt_v = '0;
  logic [79:0] key_v = '0;
  logic        core_ready_v = 1'b0;
  logic [7:0]  core_out_v = '0;
  logic        dsel = 1'b0;

  logic        busy0, done0, err0, start0, busy1, done1, err1, start1;
  logic [63:0] ct0, ct1;
  logic [7:0]  inp0, key0, inp1, key1;

  logic        req0, req1, cr0, cr1;
  assign req0 = req_v & ~dsel;
  assign req1 = req_v & dsel;
  assign cr0  = core_ready_v & ~dsel;
  assign cr1  = core_ready_v & dsel;

  logic        busy_m, done_m, err_m, start_m;
  logic [63:0] ct_m;
  logic [7:0]  inp_m, key_m;
  assign busy_m  = dsel ? busy1  : busy0;
  assign done_m  = dsel ? done1  : done0;
  assign err_m   = dsel ? err1   : err0;
  assign start_m = dsel ? start1 : start0;
  assign ct_m    = dsel ? ct1    : ct0;
  assign inp_m   = dsel ? inp1   : inp0;
  assign key_m   = dsel ? key1   : key0;

  klein80_serial_host u_dut (
    .ck(ck), .rst_n(rst_n), .req(req0), .pt(pt_v), .key80(key_v),
    .busy(busy0), .done(done0), .err(err0), .ct(ct0),
    .core_start(start0), .core_inp(inp0), .core_key(key0),
    .core_ready(cr0), .core_out(core_out_v)
  );

  klein80_serial_host #(.TIMEOUT(16)) u_dut_to (
    .ck(ck), .rst_n(rst_n), .req(req1), .pt(pt_v), .key80(key_v),
    .busy(busy1), .done(done1), .err(err1), .ct(ct1),
    .core_start(start1), .core_inp(inp1), .core_key(key1),
    .core_ready(cr1), .core_out(core_out_v)
  );

  always #5 ck = ~ck;

  int n_checks = 0;
  int n_errors = 0;

  typedef struct {
    logic [63:0] ct;
    logic        err;
  } exp_t;
  exp_t exp_q[$];

  task automatic check(input string tag, input logic [79:0] obs, input logic [79:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Scoreboard consumer: every done cycle must match the oldest expectation.
  always @(negedge ck) begin
    if (done_m) begin
      if (exp_q.size() == 0) begin
        check("unexpected_done", 1, 0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("sb_ct", ct_m, e.ct);
        check("sb_err", err_m, e.err);
      end
    end
  end

  function automatic logic [7:0] core_byte(input logic [7:0] seed, input int i);
    logic [7:0] b;
    b = 8'(8'h11 * (i + 1));
    return b ^ seed;
  endfunction

  // One operation. rdly = cycles after the first WAIT cycle before
  // core_ready (negative: never). abort_after < 8 stops after that many
  // captured bytes and returns without expecting done. Normal returns happen
  // in the cycle after done.
  task automatic run_op(input logic [63:0] p, input logic [79:0] k, input int rdly,
                        input bit started, input bit keep, input bit lpulse,
                        input int abort_after, input logic [7:0] seed);
    int n;
    int tmo;
    logic [63:0] exp_ct;
    exp_t e;
    tmo = dsel ? 16 : 1023;
    if (!started) begin
      pt_v  = p;
      key_v = k;
      req_v = 1'b1;
      n = 0;
      do begin
        @(negedge ck);
        n++;
      end while (!start_m && n < 40);
      if (!keep) req_v = 1'b0;
    end
    check("start_seen", start_m, 1);
    check("busy_load0", busy_m, 1);
    check("err_cleared", err_m, 0);
    check("ct_cleared", ct_m, 0);
    for (int c = 0; c < 10; c++) begin
      check("core_start", start_m, (c == 0));
      check("core_inp", inp_m, (c < 8) ? p[63-8*c -: 8] : 8'h00);
      check("core_key", key_m, k[79-8*c -: 8]);
      if (lpulse && c == 4) begin core_ready_v = 1'b1; core_out_v = 8'hEE; end
      if (lpulse && c == 5) begin core_ready_v = 1'b0; core_out_v = 8'h00; end
      @(negedge ck);
    end
    check("wait_inp", inp_m, 0);
    check("wait_key", key_m, 0);
    check("wait_busy", busy_m, 1);
    exp_ct = '0;
    for (int i = 0; i < 8; i++) exp_ct = {exp_ct[55:0], core_byte(seed, i)};
    if (rdly < 0) begin
      e.ct = '0; e.err = 1'b1;
      exp_q.push_back(e);
      n = 0;
      do begin
        @(negedge ck);
        n++;
      end while (!done_m && n < tmo + 10);
      check("timeout_latency", n, tmo + 1);
    end else begin
      if (abort_after >= 8) begin
        e.ct = exp_ct; e.err = 1'b0;
        exp_q.push_back(e);
      end
      repeat (rdly) @(negedge ck);
      for (int i = 0; i < 8; i++) begin
        if (i == abort_after) begin
          core_ready_v = 1'b0;
          core_out_v   = '0;
          return;
        end
        core_ready_v = (i == 0);
        core_out_v   = core_byte(seed, i);
        @(negedge ck);
      end
      core_ready_v = 1'b0;
      core_out_v   = '0;
      check("done_pulse", done_m, 1);
      check("done_busy", busy_m, 1);
    end
    @(negedge ck);
    check("busy_fall", busy_m, 0);
    check("done_one_cycle", done_m, 0);
  endtask

  localparam logic [63:0] P1 = 64'h0123456789ABCDEF;
  localparam logic [79:0] K1 = 80'hFFEEDDCCBBAA99887766;
  localparam logic [63:0] P2 = 64'hDEADBEEF00C0FFEE;
  localparam logic [79:0] K2 = 80'h0102030405060708090A;

  initial begin
    logic [63:0] first_ct;
    repeat (2) @(negedge ck);
    check("rst_busy", busy_m, 0);
    check("rst_done", done_m, 0);
    check("rst_err", err_m, 0);
    check("rst_ct", ct_m, 0);
    check("rst_start", start_m, 0);
    check("rst_inp", inp_m, 0);
    check("rst_key", key_m, 0);
    rst_n = 1'b1;
    repeat (2) @(negedge ck);

    // Basic operation, core_ready 30 cycles after start.
    run_op(P1, K1, 20, 0, 0, 0, 8, 8'h00);
    check("ct_held", ct_m, 64'h1122334455667788);

    // core_ready pulse during load cycle 5 must be ignored.
    run_op(P2, K2, 20, 0, 0, 1, 8, 8'h00);

    // Back-to-back with req held high.
    run_op(P1, K1, 12, 0, 1, 0, 8, 8'h00);
    first_ct = 64'h1122334455667788;
    pt_v  = P2;
    key_v = K2;
    check("b2b_ct_held", ct_m, first_ct);
    check("b2b_no_start_yet", start_m, 0);
    @(negedge ck);
    check("b2b_start_gap", start_m, 1);
    req_v = 1'b0;
    run_op(P2, K2, 7, 1, 0, 0, 8, 8'h5A);

    // Reset during UNLOAD after three bytes.
    run_op(P1, K1, 4, 0, 0, 0, 3, 8'h33);
    rst_n = 1'b0;
    #1;
    check("abort_busy", busy_m, 0);
    check("abort_done", done_m, 0);
    check("abort_err", err_m, 0);
    check("abort_ct", ct_m, 0);
    check("abort_start", start_m, 0);
    check("abort_inp", inp_m, 0);
    check("abort_key", key_m, 0);
    @(negedge ck);
    rst_n = 1'b1;
    for (int i = 0; i < 12; i++) begin
      @(negedge ck);
      check("post_abort_idle", {busy_m, start_m, inp_m, key_m}, 0);
    end
    run_op(P2, K2, 3, 0, 0, 0, 8, 8'hA5);

    // Timeout instance.
    @(negedge ck);
    dsel = 1'b1;
    @(negedge ck);
    run_op(P1, K1, -1, 0, 0, 0, 8, 8'h00);
    check("err_held", err_m, 1);
    check("timeout_ct", ct_m, 0);
    @(negedge ck);
    check("err_still_held", err_m, 1);
    run_op(P2, K2, 5, 0, 0, 0, 8, 8'h0F);
    // core_ready on the exact watchdog expiry cycle.
    run_op(P1, K2, 16, 0, 0, 0, 8, 8'hC3);
    check("expiry_err", err_m, 0);

    repeat (3) @(negedge ck);
    check("sb_empty", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: got running expected finished");
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors + 1);
    $fatal(1);
  end

endmodule
